bmc_lighthouse_emitter: RTL and testbench
=========================================

Name: bmc_lighthouse_emitter

Overview:
Transmit-side counterpart of the sensor receive path. Takes a 17-bit word over a valid/ready handshake and serialises it as a biphase-mark (BMC) stream on a data line, framed by an active-low envelope line, mimicking TS4231 E/D outputs. Used as an on-FPGA stimulus source for loopback tests of the BMC decoder, and to drive an IR LED emulating a lighthouse. Records the system timestamp of the first transmitted bit edge, matching the receiver's timestamp semantics.

Parameters:
DATA_BITS, 17, word length, sent MSB first
HALF_BIT_CYCLES, 8, clk cycles per half bit (8 -> 6 Mbit/s at 96 MHz); must be >= 2
LEAD_CYCLES, 16, envelope-asserted cycles before first bit edge; must be >= 1
TAIL_CYCLES, 16, envelope-asserted cycles after last bit period; must be >= 1

Ports:
clk_96MHz  in  1  sole clock
reset  in  1  synchronous, active-low (0 = reset)
tx_valid  in  1  tx_data valid
tx_ready  out  1  emitter can accept a word
tx_data  in  DATA_BITS  word to send
system_timestamp  in  24  free-running system time
e_out  out  1  envelope, active low (0 = frame in progress)
d_out  out  1  BMC data line
busy  out  1  frame in progress
tx_done  out  1  one-cycle pulse at frame end
timestamp_tx_start  out  24  system_timestamp at first bit edge of last frame

Behaviour:
- All outputs registered. In reset: e_out=1, d_out=0, busy=0, tx_ready=0, tx_done=0, timestamp_tx_start=0, FSM=IDLE, all counters 0.
- tx_ready = 1 only in IDLE with reset high. Accept on the edge where tx_valid && tx_ready; tx_data latched into shift register; tx_valid outside IDLE ignored, not queued.
- FSM IDLE -> LEAD -> DATA -> TAIL -> IDLE.
- IDLE: e_out=1, d_out=0, busy=0.
- LEAD: entered on accept edge; e_out=0, busy=1 from next cycle; d_out held at 0; lasts LEAD_CYCLES cycles.
- DATA: each bit = 2*HALF_BIT_CYCLES cycles. First cycle of each bit: d_out toggles (bit-boundary transition). Cycle HALF_BIT_CYCLES of the bit: d_out toggles again iff bit = 1. Bits MSB first, shift register shifts left per bit. Bit counter 0..DATA_BITS-1; after last bit period -> TAIL.
- On the cycle the first bit-boundary toggle is driven, timestamp_tx_start <= system_timestamp (24-bit, free wrap, no arithmetic).
- TAIL: e_out=0, d_out held at final level, TAIL_CYCLES cycles; then IDLE: e_out=1, d_out=0 same cycle, tx_done=1 for exactly that cycle, tx_ready=1 same cycle.
- Total e_out low time = LEAD_CYCLES + 2*HALF_BIT_CYCLES*DATA_BITS + TAIL_CYCLES (defaults: 16+272+16 = 304 cycles).
- Back-to-back: a word offered while tx_done is high is accepted that cycle; e_out therefore high for exactly 1 cycle between frames.
- Reset asserted mid-frame: abort next edge to reset values, no tx_done, timestamp_tx_start cleared, latched word discarded.
- Counters sized by $clog2 of their maximum; no wrap possible within a frame.

Decomposition:
- Shared package/include: BMC_HALF_BIT_96MHZ = 8, LH_DATA_BITS = 17, TIMESTAMP_W = 24, FSM state encoding (IDLE, LEAD, DATA, TAIL) — shared with bmc_decoder to keep both ends consistent.
- One sub-module: bmc_symbol_generator — half-bit timer plus toggle logic for one bit; inputs start, bit value; outputs d level, bit_done. Top holds FSM, shift register, bit/lead/tail counters, timestamp capture.

Test Plan:
- tx_data=17'h00000, defaults -> e_out low 304 cycles; d_out transitions exactly 17, spaced 16 cycles; tx_done one pulse as e_out rises.
- tx_data=17'h1FFFF -> 34 d_out transitions, spaced 8 cycles; timestamp_tx_start = system_timestamp on cycle of first toggle (check with timestamp ramping through 24'hFFFFFF wrap).
- tx_data=17'h15555 looped into bmc_decoder (d_in_0/d_in_1/e_in_0 from d_out/e_out) -> decoded_data = 17'h15555, data_availible asserted once.
- tx_valid held high continuously with two words -> second accepted on tx_done cycle; e_out high exactly 1 cycle between frames; tx_valid during busy does not change current frame.
- reset driven low at cycle 100 of a frame -> next edge e_out=1, d_out=0, busy=0, no tx_done; after release, tx_ready=1 and new frame transmits correctly.
- HALF_BIT_CYCLES=2, LEAD_CYCLES=1, TAIL_CYCLES=1, DATA_BITS=4, tx_data=4'b1010 -> e_out low 1+16+1=18 cycles, transitions at bit offsets 0,2,4,8,10,12.

Source files
------------

// File: rtl/bmc_lighthouse_emitter_pkg.sv
// Constants and FSM encoding shared by the lighthouse BMC emitter and decoder,
// so that both ends of the link agree on timing and framing.
package bmc_lighthouse_emitter_pkg;

    localparam int unsigned BMC_HALF_BIT_96MHZ = 8;
    localparam int unsigned LH_DATA_BITS       = 17;
    localparam int unsigned TIMESTAMP_W        = 24;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        DATA,
        TAIL
    } bmc_state_t;

    // Counter width for values 0..max_count-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/bmc_symbol_generator.sv
// Generates one biphase-mark symbol: toggle at the bit boundary, and a second
// toggle at mid-bit for a 1. The line level is held between symbols.
module bmc_symbol_generator
    import bmc_lighthouse_emitter_pkg::*;
#(
    parameter int unsigned HALF_BIT_CYCLES = BMC_HALF_BIT_96MHZ
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic start,
    input  logic bit_value,
    output logic d,
    output logic bit_done
);

    localparam int unsigned CW = cnt_width(2 * HALF_BIT_CYCLES);

    logic [CW-1:0] cnt;
    logic          active;
    logic          bit_q;

    assign bit_done = active && (cnt == CW'(2 * HALF_BIT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= '0;
            active <= 1'b0;
            bit_q  <= 1'b0;
            d      <= 1'b0;
        end else if (clear) begin
            cnt    <= '0;
            active <= 1'b0;
            bit_q  <= 1'b0;
            d      <= 1'b0;
        end else if (start) begin
            d      <= ~d;
            cnt    <= '0;
            active <= 1'b1;
            bit_q  <= bit_value;
        end else if (active) begin
            // Mid-bit toggle lands on cycle HALF_BIT_CYCLES of the symbol.
            if (cnt == CW'(HALF_BIT_CYCLES - 1) && bit_q) begin
                d <= ~d;
            end
            if (bit_done) begin
                active <= 1'b0;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bmc_lighthouse_emitter.sv
// Serialises a word as a BMC stream framed by an active-low envelope,
// emulating TS4231 E/D outputs, and timestamps the first bit edge.
module bmc_lighthouse_emitter
    import bmc_lighthouse_emitter_pkg::*;
#(
    parameter int unsigned DATA_BITS       = LH_DATA_BITS,
    parameter int unsigned HALF_BIT_CYCLES = BMC_HALF_BIT_96MHZ,
    parameter int unsigned LEAD_CYCLES     = 16,
    parameter int unsigned TAIL_CYCLES     = 16
) (
    input  logic                   clk_96MHz,
    input  logic                   reset,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    input  logic [DATA_BITS-1:0]   tx_data,
    input  logic [TIMESTAMP_W-1:0] system_timestamp,
    output logic                   e_out,
    output logic                   d_out,
    output logic                   busy,
    output logic                   tx_done,
    output logic [TIMESTAMP_W-1:0] timestamp_tx_start
);

    localparam int unsigned LW = cnt_width(LEAD_CYCLES);
    localparam int unsigned TW = cnt_width(TAIL_CYCLES);
    localparam int unsigned BW = cnt_width(DATA_BITS);

    bmc_state_t           state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [BW-1:0]        bit_cnt;
    logic [LW-1:0]        lead_cnt;
    logic [TW-1:0]        tail_cnt;

    logic sym_start;
    logic sym_clear;
    logic bit_done;
    logic d_level;

    // The symbol generator must see start on the very edge that begins each
    // bit, so start/clear are decoded from registered state, not registered.
    assign sym_start = ((state == LEAD) && (lead_cnt == LW'(LEAD_CYCLES - 1))) ||
                       ((state == DATA) && bit_done && (bit_cnt != BW'(DATA_BITS - 1)));
    assign sym_clear = (state == TAIL) && (tail_cnt == TW'(TAIL_CYCLES - 1));
    assign d_out     = d_level;

    bmc_symbol_generator #(
        .HALF_BIT_CYCLES(HALF_BIT_CYCLES)
    ) u_symbol (
        .clk      (clk_96MHz),
        .reset    (reset),
        .clear    (sym_clear),
        .start    (sym_start),
        .bit_value(shift_reg[DATA_BITS-1]),
        .d        (d_level),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk_96MHz) begin
        if (!reset) begin
            state              <= IDLE;
            e_out              <= 1'b1;
            busy               <= 1'b0;
            tx_ready           <= 1'b0;
            tx_done            <= 1'b0;
            timestamp_tx_start <= '0;
            shift_reg          <= '0;
            bit_cnt            <= '0;
            lead_cnt           <= '0;
            tail_cnt           <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    e_out    <= 1'b1;
                    busy     <= 1'b0;
                    tx_ready <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        state     <= LEAD;
                        shift_reg <= tx_data;
                        lead_cnt  <= '0;
                        tx_ready  <= 1'b0;
                        e_out     <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                LEAD: begin
                    if (sym_start) begin
                        state              <= DATA;
                        bit_cnt            <= '0;
                        shift_reg          <= shift_reg << 1;
                        timestamp_tx_start <= system_timestamp;
                    end else begin
                        lead_cnt <= lead_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_cnt == BW'(DATA_BITS - 1)) begin
                            state    <= TAIL;
                            tail_cnt <= '0;
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            shift_reg <= shift_reg << 1;
                        end
                    end
                end
                TAIL: begin
                    if (sym_clear) begin
                        state    <= IDLE;
                        e_out    <= 1'b1;
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                        tx_done  <= 1'b1;
                    end else begin
                        tail_cnt <= tail_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bmc_lighthouse_emitter.sv
// Randomised bench for bmc_lighthouse_emitter: frames are checked against a
// model built from bit values and frame timing, with a BMC decode of d_out.
module tb_bmc_lighthouse_emitter;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_a, valid_s;
    logic [16:0] data_a;
    logic [3:0]  data_s;
    logic [23:0] ts_base;
    logic [23:0] cyc = '0;
    logic [23:0] sys_ts;

    logic        ready_a, e_a, d_a, busy_a, done_a;
    logic [23:0] ts_a;
    logic        ready_s, e_s, d_s, busy_s, done_s;
    logic [23:0] ts_s;

    logic        sel;
    logic        m_e, m_d, m_busy, m_ready, m_done;
    logic [23:0] m_ts;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;
    always @(negedge clk) #1 cyc = cyc + 24'd1;
    assign sys_ts = ts_base + cyc;

    bmc_lighthouse_emitter dut_a (
        .clk_96MHz(clk), .reset(rst), .tx_valid(valid_a), .tx_ready(ready_a),
        .tx_data(data_a), .system_timestamp(sys_ts), .e_out(e_a), .d_out(d_a),
        .busy(busy_a), .tx_done(done_a), .timestamp_tx_start(ts_a)
    );

    bmc_lighthouse_emitter #(
        .DATA_BITS(4), .HALF_BIT_CYCLES(2), .LEAD_CYCLES(1), .TAIL_CYCLES(1)
    ) dut_s (
        .clk_96MHz(clk), .reset(rst), .tx_valid(valid_s), .tx_ready(ready_s),
        .tx_data(data_s), .system_timestamp(sys_ts), .e_out(e_s), .d_out(d_s),
        .busy(busy_s), .tx_done(done_s), .timestamp_tx_start(ts_s)
    );

    always_comb begin
        m_e = e_a; m_d = d_a; m_busy = busy_a; m_ready = ready_a; m_done = done_a; m_ts = ts_a;
        if (sel) begin
            m_e = e_s; m_d = d_s; m_busy = busy_s; m_ready = ready_s; m_done = done_s; m_ts = ts_s;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Offer a word on the selected emitter and return at the first envelope-low sample.
    task automatic start_frame(input logic [16:0] w, input bit hold);
        int unsigned n = 0;
        if (sel) begin data_s = w[3:0]; valid_s = 1'b1; end
        else     begin data_a = w;      valid_a = 1'b1; end
        @(negedge clk);
        while (m_e !== 1'b0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("accept_timeout", 32'(n < 50), 1);
        if (!hold) begin valid_a = 1'b0; valid_s = 1'b0; end
    endtask

    // Entered at the first envelope-low sample; returns at the envelope-high sample.
    task automatic check_frame(input logic [16:0] w, input int unsigned lead, input int unsigned half,
                               input int unsigned nbits, input int unsigned tail, input bit junk);
        int unsigned exp_q[$];
        int unsigned obs_q[$];
        int unsigned t = 0;
        int unsigned bad = 0;
        int k = 0;
        logic prev_d = 1'b0;
        logic bitv;
        bit got_first = 0;
        bit timeout = 0;
        logic [23:0] ts_exp = '0;
        logic [16:0] dec = '0;
        logic [16:0] w_exp;
        w_exp = w & 17'((1 << nbits) - 1);
        for (int unsigned i = 0; i < nbits; i++) begin
            exp_q.push_back(lead + 2 * half * i);
            if (w[nbits-1-i]) exp_q.push_back(lead + 2 * half * i + half);
        end
        while (m_e == 1'b0) begin
            if (m_busy !== 1'b1 || m_ready !== 1'b0 || m_done !== 1'b0) bad++;
            if (m_d !== prev_d) begin
                obs_q.push_back(t);
                if (!got_first) begin ts_exp = sys_ts; got_first = 1; end
            end
            prev_d = m_d;
            if (junk && t == lead + 3) begin
                if (sel) data_s = ~data_s; else data_a = ~data_a;
            end
            t++;
            if (t > 4000) begin timeout = 1; break; end
            @(negedge clk);
        end
        check("frame_timeout", 32'(timeout), 0);
        check("low_cycles", t, lead + 2 * half * nbits + tail);
        check("edge_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check("edge_offset", obs_q[i], exp_q[i]);
        for (int unsigned i = 0; i < nbits; i++) begin
            bitv = 1'b0;
            if (k < obs_q.size()) begin
                if (k + 1 < obs_q.size() && obs_q[k+1] - obs_q[k] == half) begin
                    bitv = 1'b1; k += 2;
                end else begin
                    k += 1;
                end
            end
            dec = {dec[15:0], bitv};
        end
        check("decoded_word", dec, w_exp);
        check("busy_ready_in_frame", bad, 0);
        check("done_at_end", m_done, 1);
        check("ready_at_end", m_ready, 1);
        check("busy_at_end", m_busy, 0);
        check("d_at_end", m_d, 0);
        check("ts_capture", m_ts, ts_exp);
    endtask

    task automatic frame_a(input logic [16:0] w);
        start_frame(w, 0);
        check_frame(w, 16, 8, 17, 16, 0);
        @(negedge clk);
        check("done_one_cycle", done_a, 0);
    endtask

    initial begin
        logic [16:0] w1, w2;
        int unsigned bad;
        sel = 0; rst = 0; valid_a = 0; valid_s = 0; data_a = '0; data_s = '0; ts_base = '0;
        repeat (3) @(negedge clk);
        check("rst_e", e_a, 1);
        check("rst_d", d_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_ready", ready_a, 0);
        check("rst_done", done_a, 0);
        check("rst_ts", ts_a, 0);
        rst = 1;
        @(negedge clk);
        check("ready_after_reset", ready_a, 1);

        ts_base = 24'hFFFFFF - cyc - 24'd17;
        frame_a(17'h00000);
        ts_base = 24'hFFFFFF - cyc - 24'd18;
        frame_a(17'h1FFFF);
        repeat (4) begin
            ts_base = 24'($urandom);
            frame_a(17'($urandom));
        end

        // Back-to-back with tx_valid held and data changed mid-frame.
        w1 = 17'($urandom);
        w2 = 17'($urandom);
        start_frame(w1, 1);
        check_frame(w1, 16, 8, 17, 16, 1);
        data_a = w2;
        @(negedge clk);
        check("gap_one_cycle", e_a, 0);
        valid_a = 0;
        check_frame(w2, 16, 8, 17, 16, 0);
        @(negedge clk);

        // Reset 100 cycles into a frame.
        start_frame(17'($urandom), 0);
        repeat (100) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("abort_e", e_a, 1);
        check("abort_d", d_a, 0);
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_ts", ts_a, 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_a !== 1'b0 || e_a !== 1'b1) bad++;
        end
        check("abort_quiet", bad, 0);
        rst = 1;
        @(negedge clk);
        check("ready_after_abort", ready_a, 1);
        frame_a(17'($urandom));

        // Minimal timing instance.
        sel = 1;
        start_frame(17'hA, 0);
        check_frame(17'hA, 1, 2, 4, 1, 0);
        repeat (3) begin
            w1 = 17'($urandom_range(0, 15));
            ts_base = 24'($urandom);
            @(negedge clk);
            start_frame(w1, 0);
            check_frame(w1, 1, 2, 4, 1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
